// File: rtl/counter_seq_pkg.sv
// Shared types for the up/down counter command sequencer: opcodes, FSM states
// and the default counter width.
package counter_seq_pkg;

    localparam int CNT_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_STEP_UP   = 2'd1,
        OP_STEP_DOWN = 2'd2,
        OP_RUN       = 2'd3
    } cnt_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_RUN,
        ST_DONE
    } cnt_seq_state_e;

endpackage

// File: rtl/counter_seq_ctrl.sv
// Command sequencer that drives an up/down counter (load, step N, run to limit).
// Optional wrap detection on STEP commands is enabled by defining CNT_SEQ_WRAP_CHK_EN.
module counter_seq_ctrl
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             load_n,
    output logic             up_down,
    output logic             ce,
    output logic [WIDTH-1:0] data_load,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             done,
    output logic             busy,
    output logic             err
);

    cnt_seq_state_e state, state_next;
    logic [WIDTH-1:0] rem_q;
    logic             up_down_q;
    logic [WIDTH-1:0] data_load_q;
    logic             accept;
    logic             limit;
    logic             run_limit_now;
    cnt_op_e          op;

    assign op     = cnt_op_e'(cmd_op);
    assign accept = cmd_valid && (state == ST_IDLE);
    assign limit  = up_down_q ? max_count : zero;
    // A RUN toward a limit the counter already sits at completes without entering RUN.
    assign run_limit_now = cmd_data[0] ? max_count : zero;

    // NOTE: every output of this block is assigned a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD:      state_next = ST_LOAD;
                        OP_STEP_UP,
                        OP_STEP_DOWN: state_next = (cmd_data == '0) ? ST_DONE : ST_STEP;
                        OP_RUN:       state_next = run_limit_now ? ST_DONE : ST_RUN;
                    endcase
                end
            end
            ST_LOAD: state_next = ST_DONE;
            ST_STEP: if (rem_q == WIDTH'(1)) state_next = ST_DONE;
            ST_RUN:  if (limit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Strobes decode straight from state so an asynchronous reset drops them at once.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign load_n    = (state != ST_LOAD);
    assign ce        = (state == ST_STEP) || ((state == ST_RUN) && !limit);
    assign up_down   = up_down_q;
    assign data_load = data_load_q;

    // NOTE: state registers use non-blocking assignments and reset asynchronously on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rem_q       <= '0;
            up_down_q   <= 1'b1;
            data_load_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rem_q <= cmd_data;
                case (op)
                    OP_LOAD:      data_load_q <= cmd_data;
                    OP_STEP_UP:   up_down_q   <= 1'b1;
                    OP_STEP_DOWN: up_down_q   <= 1'b0;
                    OP_RUN:       up_down_q   <= cmd_data[0];
                endcase
            end else if (state == ST_STEP) begin
                rem_q <= rem_q - WIDTH'(1);
            end
        end
    end

`ifdef CNT_SEQ_WRAP_CHK_EN
    logic err_q;

    // A STEP cycle with ce high while at the limit in its direction wraps the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state == ST_STEP) && limit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    logic unused_count;
    assign unused_count = ^count_out;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl: a behavioural counter closes the loop
// and a transaction-level model predicts latency, ce count, final count and err.
module tb_counter_seq_ctrl;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         load_n;
    logic         up_down;
    logic         ce;
    logic [W-1:0] data_load;
    logic [W-1:0] cnt;
    logic         max_count;
    logic         zero;
    logic         done;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .load_n    (load_n),
        .up_down   (up_down),
        .ce        (ce),
        .data_load (data_load),
        .count_out (cnt),
        .max_count (max_count),
        .zero      (zero),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    // Behavioural up/down counter standing in for the real counter instance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (!load_n) cnt <= data_load;
        else if (ce)      cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    end
    assign max_count = (cnt == W'(MAXV));
    assign zero      = (cnt == '0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_load_n"},    load_n,    1);
        check({tag, "_ce"},        ce,        0);
        check({tag, "_up_down"},   up_down,   1);
        check({tag, "_data_load"}, data_load, 0);
        check({tag, "_done"},      done,      0);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_err"},       err,       0);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // Issue one command, observe it cycle by cycle and compare against the model.
    task automatic do_cmd(input int op, input int data, input bit drop_valid);
        int start, exp_ce, exp_ld, exp_lat, exp_final, exp_err, exp_ud;
        int n_ce, n_ld, lat, tmo;
        bit dir_up;

        tmo = 0;
        while (!cmd_ready && tmo < 50) begin
            @(negedge clk);
            tmo++;
        end
        check("ready_wait", cmd_ready, 1);

        start   = exp_count;
        exp_ce  = 0;
        exp_ld  = 0;
        exp_err = 0;
        exp_ud  = 1;
        case (op)
            0: begin
                exp_ld    = 1;
                exp_lat   = 2;
                exp_final = data;
            end
            1, 2: begin
                dir_up    = (op == 1);
                exp_ud    = dir_up ? 1 : 0;
                exp_ce    = data;
                exp_lat   = data + 1;
                exp_final = dir_up ? (start + data) & MAXV : (start - data) & MAXV;
`ifdef CNT_SEQ_WRAP_CHK_EN
                exp_err   = dir_up ? ((start + data > MAXV) ? 1 : 0) : ((data > start) ? 1 : 0);
`endif
            end
            default: begin
                dir_up    = (data % 2) == 1;
                exp_ud    = dir_up ? 1 : 0;
                exp_ce    = dir_up ? MAXV - start : start;
                exp_lat   = (exp_ce == 0) ? 1 : exp_ce + 2;
                exp_final = dir_up ? MAXV : 0;
            end
        endcase

        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_data  = W'(data);
        @(negedge clk);
        if (drop_valid) cmd_valid = 1'b0;
        check("err_clr", err, 0);

        n_ce = 0;
        n_ld = 0;
        lat  = 0;
        for (int k = 1; k <= 40; k++) begin
            check("busy", busy, 1);
            check("ready_low", cmd_ready, 0);
            if (ce) begin
                n_ce++;
                check("ud_dir", up_down, exp_ud);
            end
            if (!load_n) begin
                n_ld++;
                check("dload", data_load, data);
            end
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("done_lat", lat, exp_lat);
        check("ce_cycles", n_ce, exp_ce);
        check("load_cycles", n_ld, exp_ld);

        @(negedge clk);
        check("idle_ready", cmd_ready, 1);
        check("idle_done", done, 0);
        check("count", cnt, exp_final);
        check("err", err, exp_err);
        exp_count = exp_final;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_rel");

        do_cmd(0, 4'hA, 1);
        do_cmd(0, 3, 1);
        do_cmd(1, 5, 1);
        do_cmd(0, 4'hE, 1);
        do_cmd(1, 3, 1);
        do_cmd(0, 5, 1);
        do_cmd(3, 0, 1);
        do_cmd(3, 0, 1);
        do_cmd(3, 1, 0);
        do_cmd(2, 0, 0);
        do_cmd(2, 2, 0);
        do_cmd(1, 0, 1);

        // Reset in the middle of a long STEP.
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_data  = W'(10);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_ce", ce, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        exp_count = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
        end
        check_reset_vals("post_rst");
        check("post_rst_cnt", cnt, 0);

        for (int i = 0; i < 60; i++) begin
            do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, MAXV)),
                   bit'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
